// File: rtl/pb_debounce_event.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce FSM, and registered
// press/release/long-press strobes plus a modulo-256 press counter.
module pb_debounce_event #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PB_SW_N,
    output logic       PB_LEVEL,
    output logic       PRESS_PULSE,
    output logic       RELEASE_PULSE,
    output logic       LONG_PULSE,
    output logic [7:0] PRESS_COUNT
);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        LONG_HELD,
        RELEASE_WAIT
    } state_t;

    logic          sync1, sync2;
    state_t        state_q, state_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          from_long_q, from_long_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;
    logic [7:0]    count_q, count_d;

    // State, counters, synchronizer and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_q      <= '0;
            from_long_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            sync1       <= PB_SW_N;
            sync2       <= sync1;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_q      <= hold_d;
            from_long_q <= from_long_d;
            level_q     <= level_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            long_q      <= long_d;
            count_q     <= count_d;
        end
    end

    // Next-state and next-output logic; sync2 low means the button is down
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_d      = hold_q;
        from_long_d = from_long_q;
        level_d     = level_q;
        press_d     = 1'b0;
        rel_d       = 1'b0;
        long_d      = 1'b0;
        count_d     = count_q;

        case (state_q)
            IDLE: begin
                if (!sync2) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = DW'(1);
                end
            end
            PRESS_WAIT: begin
                if (sync2) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                    hold_d   = '0;
                    press_d  = 1'b1;
                    level_d  = 1'b1;
                    count_d  = count_q + 8'd1;
                end else begin
                    db_cnt_d = db_cnt_q + DW'(1);
                end
            end
            PRESSED: begin
                if (sync2) begin
                    state_d     = RELEASE_WAIT;
                    db_cnt_d    = DW'(1);
                    from_long_d = 1'b0;
                end else if (hold_q >= HOLD_LAST) begin
                    state_d = LONG_HELD;
                    hold_d  = HOLD_MAX;
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            LONG_HELD: begin
                if (sync2) begin
                    state_d     = RELEASE_WAIT;
                    db_cnt_d    = DW'(1);
                    from_long_d = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                // Hold counter stays frozen so a bounce resumes the long-press timing
                if (!sync2) begin
                    state_d  = from_long_q ? LONG_HELD : PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                    rel_d    = 1'b1;
                    level_d  = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                db_cnt_d = '0;
                hold_d   = '0;
                level_d  = 1'b0;
            end
        endcase
    end

    assign PB_LEVEL      = level_q;
    assign PRESS_PULSE   = press_q;
    assign RELEASE_PULSE = rel_q;
    assign LONG_PULSE    = long_q;
    assign PRESS_COUNT   = count_q;

endmodule
